// File: rtl/ascon_perm_engine.sv
// Ascon v1.2 permutation engine: INIT / DATA / FINAL command sequencer, UNROLL rounds per clock.
// Optional tag comparison (tag_ref_i / tag_ok_o) is enabled by defining ASCON_TAG_CHECK_EN.
module ascon_perm_engine #(
    parameter int UNROLL          = 1,
    parameter bit DECRYPT_DEFAULT = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic         decrypt_i,
    input  logic         dsep_i,
    input  logic [319:0] state_i,
    input  logic [127:0] key_i,
    input  logic [63:0]  data_i,
`ifdef ASCON_TAG_CHECK_EN
    input  logic [127:0] tag_ref_i,
    output logic         tag_ok_o,
`endif
    output logic         busy_o,
    output logic         done_o,
    output logic [63:0]  data_o,
    output logic [127:0] tag_o,
    output logic [319:0] state_o
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
        $error("ascon_perm_engine: UNROLL must be 1, 2, 3 or 6");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
    typedef enum logic [1:0] {OP_INIT = 2'b00, OP_DATA = 2'b01, OP_FINAL = 2'b10, OP_RSVD = 2'b11} op_e;

    localparam logic [3:0] STEP = 4'(UNROLL);

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, ~r, r};
        x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
        x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    fsm_e           r_fsm, w_fsm_nxt;
    op_e            r_op, w_op;
    logic           r_dsep, r_mode, w_mode, w_accept, w_last;
    logic [3:0]     r_rnd;
    logic [319:0]   r_s, w_perm, w_end, w_begin;
    logic [63:0]    r_data, w_dout;
    logic [127:0]   r_tag, w_tag;

    assign w_op     = op_e'(op_i);
    assign w_accept = start_i && (r_fsm != RUN) && (w_op != OP_RSVD);
    // Mode follows decrypt_i on the accept edge so the begin operation sees the new command's mode.
    assign w_mode   = w_accept ? decrypt_i : r_mode;
    assign w_last   = (r_rnd + STEP) == 4'd12;

    always_comb begin
        w_perm = r_s;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            w_perm = ascon_round(w_perm, r_rnd + 4'(i));
        end
    end

    always_comb begin
        w_end = w_perm;
        w_tag = w_perm[127:0] ^ key_i;
        if (r_op != OP_DATA) w_end[127:0] = w_tag;
        if (r_dsep) w_end[0] = ~w_end[0];
    end

    always_comb begin
        w_begin = r_s;
        w_dout  = r_data;
        if (w_op == OP_DATA || w_op == OP_FINAL) begin
            if (w_mode) begin
                w_dout            = r_s[319:256] ^ data_i;
                w_begin[319:256]  = data_i;
            end else begin
                w_begin[319:256]  = r_s[319:256] ^ data_i;
                w_dout            = w_begin[319:256];
            end
        end
        if (w_op == OP_FINAL) w_begin[255:128] = r_s[255:128] ^ key_i;
        if (w_op == OP_INIT)  w_begin = state_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_fsm <= IDLE;
        else       r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE, DONE: w_fsm_nxt = w_accept ? RUN : IDLE;
            RUN:        if (w_last) w_fsm_nxt = DONE;
            default:    w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op   <= OP_INIT;
            r_dsep <= 1'b0;
            r_mode <= DECRYPT_DEFAULT;
            r_rnd  <= '0;
            r_s    <= '0;
            r_data <= '0;
            r_tag  <= '0;
        end else begin
            r_mode <= w_mode;
            if (w_accept) begin
                r_op   <= w_op;
                r_dsep <= dsep_i;
                r_s    <= w_begin;
                r_rnd  <= (w_op == OP_DATA) ? 4'd6 : 4'd0;
                r_data <= w_dout;
            end else if (r_fsm == RUN) begin
                r_rnd <= r_rnd + STEP;
                if (w_last) begin
                    r_s <= w_end;
                    if (r_op == OP_FINAL) r_tag <= w_tag;
                end else begin
                    r_s <= w_perm;
                end
            end
        end
    end

`ifdef ASCON_TAG_CHECK_EN
    logic r_tag_ok;
    always_ff @(posedge clk_i) begin
        if (rst_i) r_tag_ok <= 1'b0;
        else if (r_fsm == RUN && w_last && r_op == OP_FINAL)
            r_tag_ok <= r_mode && (w_tag == tag_ref_i);
    end
    assign tag_ok_o = r_tag_ok;
`endif

    assign busy_o  = (r_fsm == RUN);
    assign done_o  = (r_fsm == DONE);
    assign data_o  = r_data;
    assign tag_o   = r_tag;
    assign state_o = r_s;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Directed bench for ascon_perm_engine: four instances (UNROLL 1, 2, 3, 6) share data inputs.
// Define ASCON_TAG_CHECK_EN to also exercise tag_ref_i / tag_ok_o.
module tb_ascon_perm_engine;

    localparam logic [127:0] KEY    = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [319:0] KAT_ST = {64'h80400C0600000000, KEY, KEY};
    localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;
    localparam logic [63:0]  PAD    = 64'h8000000000000000;
    localparam logic [63:0]  PT     = 64'h4120746F20428000;
    localparam int EXP_INIT [4] = '{13, 7, 5, 3};
    localparam int EXP_DATA [4] = '{7, 4, 3, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   start;
    logic [1:0]   op;
    logic         dec, dsep;
    logic [319:0] st_in;
    logic [127:0] key;
    logic [63:0]  din;
    logic [3:0]   busy, done;
    logic [63:0]  dout [4];
    logic [127:0] tag [4];
    logic [319:0] sto [4];
`ifdef ASCON_TAG_CHECK_EN
    logic [127:0] tag_ref;
    logic [3:0]   tag_ok;
`endif

    int n_vec = 0;
    int n_err = 0;
    int lat [4];
    int ndone [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ascon_perm_engine #(
            .UNROLL          (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : 6),
            .DECRYPT_DEFAULT (1'b0)
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .start_i   (start[g]),
            .op_i      (op),
            .decrypt_i (dec),
            .dsep_i    (dsep),
            .state_i   (st_in),
            .key_i     (key),
            .data_i    (din),
`ifdef ASCON_TAG_CHECK_EN
            .tag_ref_i (tag_ref),
            .tag_ok_o  (tag_ok[g]),
`endif
            .busy_o    (busy[g]),
            .done_o    (done[g]),
            .data_o    (dout[g]),
            .tag_o     (tag[g]),
            .state_o   (sto[g])
        );
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = '0;
        tick();
        rst = 1'b0;
    endtask

    // Issues one command on the masked instances; records per-instance latency (edges counted
    // from the accept edge inclusive) and number of done cycles seen within the window.
    task automatic run_cmd(input logic [3:0] mask, input logic [1:0] o, input logic d,
                           input logic ds, input logic [63:0] di, input int cycles);
        op = o; dec = d; dsep = ds; din = di; start = mask;
        for (int k = 0; k < 4; k++) begin lat[k] = 0; ndone[k] = 0; end
        for (int n = 1; n <= cycles; n++) begin
            tick();
            if (n == 1) start = '0;
            for (int k = 0; k < 4; k++) begin
                if (done[k]) begin
                    ndone[k]++;
                    if (lat[k] == 0) lat[k] = n;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = '0;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({busy[k], done[k], dout[k], tag[k], sto[k]} !== '0) begin
                n_err++;
                $display("FAIL reset u%0d: busy=%b done=%b data=%h tag=%h state_nonzero=%b, need all zero",
                         k, busy[k], done[k], dout[k], tag[k], |sto[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reserved_op;
        run_cmd(4'hF, 2'b11, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (ndone[k] !== 0 || busy[k] !== 1'b0 || sto[k] !== '0 || dout[k] !== '0) begin
                n_err++;
                $display("FAIL reserved_op u%0d: done_cycles=%0d busy=%b state_nonzero=%b data=%h, need 0/0/0/0",
                         k, ndone[k], busy[k], |sto[k], dout[k]);
            end
        end
    endtask

    task automatic test_kat;
        st_in = KAT_ST;
        run_cmd(4'hF, 2'b00, 1'b0, 1'b1, '0, 20);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (lat[k] !== EXP_INIT[k] || ndone[k] !== 1) begin
                n_err++;
                $display("FAIL init_latency u%0d: latency=%0d done_cycles=%0d, need %0d/1",
                         k, lat[k], ndone[k], EXP_INIT[k]);
            end
        end
        run_cmd(4'hF, 2'b10, 1'b0, 1'b0, PAD, 20);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (lat[k] !== EXP_INIT[k] || ndone[k] !== 1) begin
                n_err++;
                $display("FAIL final_latency u%0d: latency=%0d done_cycles=%0d, need %0d/1",
                         k, lat[k], ndone[k], EXP_INIT[k]);
            end
            n_vec++;
            if (tag[k] !== KAT_TAG) begin
                n_err++;
                $display("FAIL kat_tag u%0d: got %h need %h", k, tag[k], KAT_TAG);
            end
        end
    endtask

    task automatic test_tag_hold;
        run_cmd(4'hF, 2'b00, 1'b0, 1'b0, '0, 20);
        run_cmd(4'hF, 2'b01, 1'b0, 1'b0, PT, 12);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (tag[k] !== KAT_TAG) begin
                n_err++;
                $display("FAIL tag_hold u%0d: got %h need %h", k, tag[k], KAT_TAG);
            end
        end
    endtask

    task automatic test_data_latency;
        run_cmd(4'hF, 2'b01, 1'b0, 1'b0, 64'h0123456789ABCDEF, 12);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (lat[k] !== EXP_DATA[k] || ndone[k] !== 1) begin
                n_err++;
                $display("FAIL data_latency u%0d: latency=%0d done_cycles=%0d, need %0d/1",
                         k, lat[k], ndone[k], EXP_DATA[k]);
            end
        end
    endtask

    task automatic test_handshake;
        int nd, nrise, lat2;
        logic prev, found;
        op = 2'b01; dec = 1'b0; dsep = 1'b0; din = PT;
        start = 4'b0001; nd = 0; nrise = 0; prev = busy[0];
        for (int n = 1; n <= 25; n++) begin
            tick();
            if (n == 5) start = '0;
            if (busy[0] && !prev) nrise++;
            prev = busy[0];
            if (done[0]) nd++;
        end
        n_vec++;
        if (nd !== 1 || nrise !== 1) begin
            n_err++;
            $display("FAIL held_start: done_cycles=%0d commands=%0d, need 1/1", nd, nrise);
        end
        start = 4'b0001;
        tick();
        start = '0; found = 1'b0;
        for (int n = 2; n <= 20 && !found; n++) begin
            tick();
            if (done[0]) found = 1'b1;
        end
        start = 4'b0001;
        tick();
        start = '0;
        n_vec++;
        if (found !== 1'b1 || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back: first_done=%b busy=%b done=%b, need 1/1/0", found, busy[0], done[0]);
        end
        lat2 = 0;
        for (int n = 2; n <= 20; n++) begin
            tick();
            if (done[0] && lat2 == 0) lat2 = n;
        end
        n_vec++;
        if (lat2 !== 7) begin
            n_err++;
            $display("FAIL back_to_back_latency: got %0d need 7", lat2);
        end
    endtask

    task automatic test_reset_abort;
        int nd;
        st_in = KAT_ST; op = 2'b00; dec = 1'b0; dsep = 1'b1; start = 4'b0001;
        tick();
        start = '0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || sto[0] !== '0 || tag[0] !== '0) begin
            n_err++;
            $display("FAIL reset_abort u0: busy=%b done=%b state_nonzero=%b tag=%h, need all zero",
                     busy[0], done[0], |sto[0], tag[0]);
        end
        nd = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done[0]) nd++;
        end
        n_vec++;
        if (nd !== 0) begin
            n_err++;
            $display("FAIL reset_abort_no_done: done_cycles=%0d need 0", nd);
        end
    endtask

    task automatic test_round_trip;
        logic [63:0]  c0;
        logic [319:0] s_enc [4];
        do_reset();
        st_in = KAT_ST;
        run_cmd(4'hF, 2'b00, 1'b0, 1'b0, '0, 20);
        run_cmd(4'hF, 2'b01, 1'b0, 1'b0, PT, 12);
        c0 = dout[0];
        for (int k = 0; k < 4; k++) s_enc[k] = sto[k];
        for (int k = 1; k < 4; k++) begin
            n_vec++;
            if (dout[k] !== c0) begin
                n_err++;
                $display("FAIL enc_agree u%0d: ct=%h need %h (UNROLL=1 instance)", k, dout[k], c0);
            end
        end
        do_reset();
        run_cmd(4'hF, 2'b00, 1'b0, 1'b0, '0, 20);
        run_cmd(4'hF, 2'b01, 1'b1, 1'b0, c0, 12);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (dout[k] !== PT) begin
                n_err++;
                $display("FAIL dec_plaintext u%0d: got %h need %h", k, dout[k], PT);
            end
            n_vec++;
            if (sto[k] !== s_enc[k]) begin
                n_err++;
                $display("FAIL dec_state u%0d: got %h need %h", k, sto[k], s_enc[k]);
            end
        end
    endtask

`ifdef ASCON_TAG_CHECK_EN
    task automatic test_tag_check;
        logic [63:0] d;
        logic        exp_ok;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            st_in = KAT_ST;
            run_cmd(4'hF, 2'b00, 1'b0, 1'b1, '0, 20);
            d = (t == 2) ? PAD : (sto[0][319:256] ^ PAD);
            tag_ref = (t == 1) ? (KAT_TAG ^ 128'h1) : KAT_TAG;
            exp_ok = (t == 0);
            run_cmd(4'hF, 2'b10, (t != 2), 1'b0, d, 20);
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (tag_ok[k] !== exp_ok || tag[k] !== KAT_TAG) begin
                    n_err++;
                    $display("FAIL tag_check case%0d u%0d: tag_ok=%b tag=%h, need %b/%h",
                             t, k, tag_ok[k], tag[k], exp_ok, KAT_TAG);
                end
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = '0; op = '0; dec = 1'b0; dsep = 1'b0;
        st_in = '0; key = KEY; din = '0;
`ifdef ASCON_TAG_CHECK_EN
        tag_ref = '0;
`endif
        test_reset();
        test_reserved_op();
        test_kat();
        test_tag_hold();
        test_data_latency();
        test_handshake();
        test_reset_abort();
        test_round_trip();
`ifdef ASCON_TAG_CHECK_EN
        test_tag_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ascon_perm_engine.md
ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
- REQ-001 SHALL have parameter UNROLL, default 1: permutation rounds per clock; legal values 1, 2, 3, 6; any other value SHALL stop elaboration.
- REQ-002 SHALL have parameter DECRYPT_DEFAULT, default 0: value of mode_q after reset (0 = encrypt, 1 = decrypt).
- REQ-003 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock, rising edge; rst_i  in  1  reset.
- REQ-004 SHALL have these control inputs:
  - start_i  in  1  command request.
  - op_i  in  2  command: 00 INIT, 01 DATA, 10 FINAL, 11 reserved.
  - decrypt_i  in  1  mode, latched with each command.
  - dsep_i  in  1  domain-separation request: XOR 1 into x4 LSB at end of op.
- REQ-005 SHALL have these data inputs:
  - state_i  in  320  initial state {x0..x4}, used by INIT only.
  - key_i  in  128  key K.
  - data_i  in  64  plaintext or ciphertext block, already padded.
- REQ-006 SHALL have these outputs:
  - busy_o  out  1  command in progress.
  - done_o  out  1  one-cycle completion pulse.
  - data_o  out  64  ciphertext or plaintext.
  - tag_o  out  128  tag.
  - state_o  out  320  current state.

Function
- REQ-007 SHALL use FSM states IDLE, RUN, DONE; start_i SHALL be accepted only in IDLE or DONE, and ignored in RUN.
- REQ-008 On the accept edge the block SHALL latch op_i, decrypt_i and dsep_i, apply the begin operation, and load round counter r:
  - INIT: S=state_i, r=0.
  - DATA: r=6.
  - FINAL: r=0, x1||x2 ^= K.
- REQ-009 DATA/FINAL begin, encrypt: x0 ^= data_i; data_o = new x0.
- REQ-010 DATA/FINAL begin, decrypt: data_o = x0 ^ data_i; x0 = data_i.
- REQ-011 data_o SHALL be registered on the accept edge and held until the next accepted DATA/FINAL.
- REQ-012 Each RUN edge SHALL apply UNROLL rounds with constants c_r = ((15-r)<<4)|r, r..r+UNROLL-1; each round is pC, pS, pL per ASCON v1.2; then r += UNROLL.
- REQ-013 On the RUN edge where r reaches 12, the end operation SHALL be applied and the FSM SHALL go to DONE:
  - INIT and FINAL: x3||x4 ^= K.
  - FINAL: tag_o = x3||x4, taken after that XOR.
  - If dsep latched: x4[0] ^= 1, applied after the key XOR.
- REQ-014 Latency from accept edge to done_o high SHALL be 1 + 12/UNROLL cycles for INIT and FINAL, and 1 + 6/UNROLL cycles for DATA.
- REQ-015 busy_o SHALL be high exactly in RUN; done_o SHALL be high exactly in DONE.
- REQ-016 DONE SHALL last one cycle, then go to IDLE; start_i in DONE SHALL be accepted back-to-back.
- REQ-017 op_i=11 SHALL be ignored (no state change, no done_o).
- REQ-018 tag_o SHALL change only at FINAL completion.

Reset
- REQ-019 rst_i high at an edge SHALL force FSM=IDLE, r=0, state=0, data_o=0, tag_o=0, done_o=0, busy_o=0, mode_q=DECRYPT_DEFAULT.
- REQ-020 rst_i SHALL take priority over start_i; reset during RUN SHALL abort the op with no done_o pulse.

Configuration
- REQ-021 Macro ASCON_TAG_CHECK_EN, when defined, SHALL add:
  - tag_ref_i  in  128  expected tag.
  - tag_ok_o  out  1  tag match.
  - tag_ok_o SHALL be registered at FINAL completion as (tag == tag_ref_i) when decrypt is latched, and forced to 0 in encrypt.
  - tag_ok_o SHALL reset to 0.
- REQ-022 Without the macro, those ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
- REQ-023 Ascon-128 v1.2 KAT Count=1, run for UNROLL 1, 2, 3, 6:
  - Stimulus: K = N = 000102..0F, empty AD, empty PT.
  - Sequence: INIT with dsep=1, then FINAL with data_i=8000000000000000.
  - Required: tag_o = E355159F292911F794CB1432A0103A8A.
- REQ-024 Latency: INIT with UNROLL=1 -> done_o high exactly 13 cycles after the accept edge; DATA with UNROLL=3 -> 3 cycles.
- REQ-025 Encrypt/decrypt round trip: encrypt DATA block 4120746F20428000 from a fixed state, then decrypt the returned ciphertext from the same state -> data_o = 4120746F20428000 and identical state_o.
- REQ-026 Handshake: start_i held high through RUN -> exactly one command executed and one done_o pulse; start_i in DONE -> next op accepted on that edge.
- REQ-027 Reset: rst_i asserted 4 cycles into an INIT -> next cycle busy_o=0, done_o=0, state_o=0, tag_o=0, and no done_o pulse thereafter.
- REQ-028 With ASCON_TAG_CHECK_EN: decrypt KAT with the correct tag_ref_i -> tag_ok_o=1; with one bit flipped -> 0; encrypt mode -> 0.
